// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts a valid/ready command stream into APB3 transfers, one in flight at a time.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYCLES cycles (rsp_err=1).
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high, PSEL low
// SETUP  | PSEL high, PENABLE low; address, direction and write data presented
// ACCESS | PSEL and PENABLE high; waiting for PREADY (or timeout)
// RESP   | response held stable until rsp_ready; PSEL low

module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    psel_nx;
    logic                    penable_nx;
    logic                    pwrite_nx;
    logic                    rsp_valid_nx;
    logic [ADDR_WIDTH-1:0]   paddr_nx;
    logic [DATA_WIDTH-1:0]   pwdata_nx;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nx;
    logic                    timeout_hit;
    logic                    access_done;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    assign cmd_ready   = (state == S_IDLE);
    assign access_done = PREADY || timeout_hit;

`ifdef APB_TIMEOUT_EN
    // Counter holds TIMEOUT_CYCLES-1 at most before the abort, so one extra bit is ample.
    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt;
    logic             rsp_err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            timeout_cnt <= '0;
        end else if (state == S_SETUP) begin
            timeout_cnt <= '0;
        end else if (state == S_ACCESS && !PREADY) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // PREADY on the terminal edge wins, so the abort needs PREADY low.
    assign timeout_hit = (state == S_ACCESS) && !PREADY && (timeout_cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_err_q <= 1'b0;
        end else if (state == S_ACCESS && access_done) begin
            rsp_err_q <= timeout_hit;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nx;
            PSEL      <= psel_nx;
            PENABLE   <= penable_nx;
            PWRITE    <= pwrite_nx;
            PADDR     <= paddr_nx;
            PWDATA    <= pwdata_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        psel_nx      = PSEL;
        penable_nx   = PENABLE;
        pwrite_nx    = PWRITE;
        paddr_nx     = PADDR;
        pwdata_nx    = PWDATA;
        rsp_valid_nx = rsp_valid;
        rsp_rdata_nx = rsp_rdata;

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    pwrite_nx  = cmd_write;
                    paddr_nx   = cmd_addr;
                    pwdata_nx  = cmd_wdata;
                    psel_nx    = 1'b1;
                    penable_nx = 1'b0;
                    state_nx   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_nx = 1'b1;
                state_nx   = S_ACCESS;
            end
            S_ACCESS: begin
                if (access_done) begin
                    psel_nx      = 1'b0;
                    penable_nx   = 1'b0;
                    rsp_valid_nx = 1'b1;
                    // PRDATA reaches the response only on a successful read completion.
                    rsp_rdata_nx = (PREADY && !PWRITE) ? PRDATA : '0;
                    state_nx     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    state_nx     = S_IDLE;
                end
            end
            default: begin
                psel_nx      = 1'b0;
                penable_nx   = 1'b0;
                rsp_valid_nx = 1'b0;
                state_nx     = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table of single transfers plus
// hand-written wait-state, response-hold, back-to-back, reset and timeout sequences.
module tb_apb_master_bridge;

`ifdef APB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_master_bridge #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    // APB register slave: 4 words, PREADY held low for 'stall' ACCESS cycles.
    logic [31:0] regs [4];
    int          stall = 0;
    int          acc_cnt;
    int          xfers = 0;

    assign PREADY = (acc_cnt >= stall);
    assign PRDATA = (PSEL && PENABLE) ? regs[PADDR[3:2]] : 32'hDEADBEEF;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < 4; i++) regs[i] <= 32'h0;
            acc_cnt <= 0;
        end else if (PSEL && PENABLE) begin
            if (PREADY) begin
                acc_cnt <= 0;
                xfers   <= xfers + 1;
                if (PWRITE) regs[PADDR[3:2]] <= PWDATA;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One command; expected latency counted in edges from the acceptance edge to rsp_valid.
    task automatic do_cmd(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int lat;
        int pen;
        int held_bad;
        int proto_bad;
        int hold_bad;
        logic [1:0] pat1;
        logic [1:0] pat2;
        logic [31:0] rd0;
        lat = 0; pen = 0; held_bad = 0; proto_bad = 0; hold_bad = 0;
        pat1 = 2'b00; pat2 = 2'b00;
        @(negedge PCLK);
        rsp_ready = (hold == 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        chk({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        do begin
            @(negedge PCLK);
            lat++;
            if (lat == 1) begin
                cmd_valid = 1'b0;
                pat1 = {PSEL, PENABLE};
            end
            if (lat == 2) pat2 = {PSEL, PENABLE};
            if (PENABLE) pen++;
            if (PSEL && (PADDR != addr || PWRITE != wr || (wr && PWDATA != wdata))) held_bad++;
            if ((PENABLE && !PSEL) || (rsp_valid && PSEL)) proto_bad++;
        end while (!rsp_valid && lat < 60);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " sel_en_pattern"}, {28'd0, pat1, pat2}, 32'b1011);
        chk({tag, " penable_cycles"}, 32'(pen), 32'(exp_lat - 2));
        chk({tag, " apb_held"}, 32'(held_bad + proto_bad), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        rd0 = rsp_rdata;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge PCLK);
                if (!rsp_valid || rsp_rdata != rd0 || cmd_ready || PSEL) hold_bad++;
            end
            chk({tag, " rsp_hold_stable"}, 32'(hold_bad), 32'd0);
            rsp_ready = 1'b1;
        end
        @(negedge PCLK);
        chk({tag, " post_handshake"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];
    time  t_acc[4];
    int   x0;
    int   g;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"wr04", 1'b1, 8'h04, 32'hA5A5_0001, 32'h0};
        vecs[1] = '{"rd04", 1'b0, 8'h04, 32'h0,         32'hA5A5_0001};
        vecs[2] = '{"wr08", 1'b1, 8'h08, 32'h1234_5678, 32'h0};
        vecs[3] = '{"wr0C", 1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0};
        vecs[4] = '{"rd08", 1'b0, 8'h08, 32'h0,         32'h1234_5678};
        vecs[5] = '{"rd00", 1'b0, 8'h00, 32'h0,         32'h0};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("reset apb_ctrl", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
        chk("reset paddr", 32'(PADDR), 32'd0);
        chk("reset pwdata", PWDATA, 32'd0);
        chk("reset rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++)
            do_cmd(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 3, vecs[i].exp_rdata, 1'b0, 0);

        // Three wait states on a read of 0x08.
        stall = 3;
        do_cmd("wait3", 1'b0, 8'h08, 32'h0, 6, 32'h1234_5678, 1'b0, 0);
        stall = 0;

        // Consumer stalls the response for 5 cycles.
        do_cmd("hold5", 1'b0, 8'h04, 32'h0, 3, 32'hA5A5_0001, 1'b0, 5);

        // Four queued writes with cmd_valid held high.
        @(negedge PCLK);
        x0 = xfers;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_write = 1'b1;
            cmd_addr  = 8'(i * 4);
            cmd_wdata = 32'hC0DE_0000 + 32'(i);
            g = 0;
            while (!cmd_ready && g < 20) begin
                @(negedge PCLK);
                g++;
            end
            t_acc[i] = $time;
            @(posedge PCLK);
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        repeat (5) @(negedge PCLK);
        for (int i = 1; i < 4; i++) chk("b2b spacing", 32'(t_acc[i] - t_acc[i-1]), 32'd40);
        chk("b2b xfers", 32'(xfers - x0), 32'd4);
        for (int i = 0; i < 4; i++) chk("b2b slave_reg", regs[i], 32'hC0DE_0000 + 32'(i));

        // Reset in the middle of a stalled ACCESS phase.
        stall = 1000;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h04;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("midrst in_access", {30'd0, PSEL, PENABLE}, 32'b11);
        #1 PRESETn = 1'b0;
        #1 chk("midrst apb_drop", {29'd0, PSEL, PENABLE, rsp_valid}, 32'd0);
        repeat (2) @(negedge PCLK);
        stall = 0;
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("midrst after", {30'd0, cmd_ready, rsp_valid}, 32'b10);
        do_cmd("postrst_wr", 1'b1, 8'h08, 32'h5A5A_5A5A, 3, 32'h0, 1'b0, 0);
        do_cmd("postrst_rd", 1'b0, 8'h08, 32'h0, 3, 32'h5A5A_5A5A, 1'b0, 0);

`ifdef APB_TIMEOUT_EN
        stall = 1000;
        do_cmd("timeout", 1'b0, 8'h08, 32'h0, 6, 32'h0, 1'b1, 0);
        stall = 3;
        do_cmd("late_ready", 1'b0, 8'h08, 32'h0, 6, 32'h5A5A_5A5A, 1'b0, 0);
        stall = 0;
        do_cmd("after_to", 1'b0, 8'h08, 32'h0, 3, 32'h5A5A_5A5A, 1'b0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
